fetch_unit: RTL and testbench

- IF stage and IF/ID register for the non-forwarding pipelined RV32I core.
- Consumer side of the next-PC interface. The next-PC mux supplies i_pc_next and i_br_taken; this block returns the current fetch PC+4 and the ID-stage PC that the mux reads.
- Owns the PC register and the instruction-memory request/acknowledge handshake. Handles stall from the hazard unit and flush on branch/jump redirect, including a redirect that arrives while a fetch is still outstanding.

---
 rtl/core_pkg.sv | 17 +
 rtl/if_id_reg.sv | 40 ++++
 rtl/fetch_unit.sv | 166 ++++++++++++++++
 tb/tb_fetch_unit.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/core_pkg.sv
// Shared types and constants for the RV32I pipeline front end.
package core_pkg;

    localparam int unsigned XLEN = 32;

    // addi x0, x0, 0
    localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

    localparam logic [6:0] OPC_JALR = 7'b110_0111;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        HOLD  = 2'd1,
        DRAIN = 2'd2
    } fetch_state_e;

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: flush inserts a NOP bubble, hold freezes, load captures.
module if_id_reg
    import core_pkg::*;
#(
    parameter logic [XLEN-1:0] NOP = NOP_INSTR
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            hold,
    input  logic            load,
    input  logic [XLEN-1:0] pc,
    input  logic [XLEN-1:0] instr,
    output logic [XLEN-1:0] pc_id,
    output logic [XLEN-1:0] instr_id,
    output logic            valid_id
);

    // Flush beats hold beats load; otherwise a bubble enters ID (PC left as-is).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_id    <= '0;
            instr_id <= NOP;
            valid_id <= 1'b0;
        end else if (flush) begin
            instr_id <= NOP;
            valid_id <= 1'b0;
        end else if (!hold) begin
            if (load) begin
                pc_id    <= pc;
                instr_id <= instr;
                valid_id <= 1'b1;
            end else begin
                instr_id <= NOP;
                valid_id <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// IF stage: PC register, imem req/ack handshake, stall/flush handling and IF/ID register.
module fetch_unit #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic [31:0] i_pc_next,
    input  logic        i_br_taken,
    input  logic        i_stall_id,
    output logic        o_imem_req,
    output logic [31:0] o_imem_addr,
    input  logic        i_imem_ack,
    input  logic [31:0] i_imem_rdata,
    output logic [31:0] o_pc_plus4_if,
    output logic [31:0] o_pc_id,
    output logic [31:0] o_instr_id,
    output logic        o_valid_id
);

    import core_pkg::*;

    localparam logic [XLEN-1:0] ALIGN_MASK = ~XLEN'(3);

    fetch_state_e    state_q;
    fetch_state_e    state_d;
    logic [XLEN-1:0] pc_q;
    logic [XLEN-1:0] pend_q;
    logic [XLEN-1:0] buf_q;
    logic [XLEN-1:0] pc_src;
    logic [XLEN-1:0] id_instr;
    logic            ack;
    logic            id_flush;
    logic            id_hold;
    logic            id_load;
    logic            id_from_buf;
    logic            pc_load;
    logic            pc_from_pend;
    logic            pend_load;
    logic            buf_load;

    // Request is dropped immediately on reset; ack only counts while requesting.
    assign o_imem_req    = !i_reset && (state_q != HOLD);
    assign o_imem_addr   = pc_q;
    assign o_pc_plus4_if = pc_q + XLEN'(4);
    assign ack           = i_imem_ack && o_imem_req;
    assign pc_src        = pc_from_pend ? pend_q : i_pc_next;
    assign id_instr      = id_from_buf ? buf_q : i_imem_rdata;

    // State register.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state_q <= FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            FETCH: begin
                if (i_br_taken) begin
                    state_d = ack ? FETCH : DRAIN;
                end else if (ack && i_stall_id) begin
                    state_d = HOLD;
                end
            end
            HOLD: begin
                if (i_br_taken || !i_stall_id) begin
                    state_d = FETCH;
                end
            end
            DRAIN: begin
                if (ack) begin
                    state_d = FETCH;
                end
            end
            default: state_d = FETCH;
        endcase
    end

    // Datapath controls: redirect flushes ID in every state.
    always_comb begin
        id_flush     = i_br_taken;
        id_hold      = 1'b0;
        id_load      = 1'b0;
        id_from_buf  = 1'b0;
        pc_load      = 1'b0;
        pc_from_pend = 1'b0;
        pend_load    = 1'b0;
        buf_load     = 1'b0;
        unique case (state_q)
            FETCH: begin
                if (i_br_taken) begin
                    pc_load   = ack;
                    pend_load = !ack;
                end else if (ack && !i_stall_id) begin
                    id_load = 1'b1;
                    pc_load = 1'b1;
                end else if (ack) begin
                    buf_load = 1'b1;
                    id_hold  = 1'b1;
                end else begin
                    id_hold = i_stall_id;
                end
            end
            HOLD: begin
                if (i_br_taken) begin
                    pc_load = 1'b1;
                end else if (i_stall_id) begin
                    id_hold = 1'b1;
                end else begin
                    id_load     = 1'b1;
                    id_from_buf = 1'b1;
                    pc_load     = 1'b1;
                end
            end
            DRAIN: begin
                id_hold   = i_stall_id;
                pend_load = i_br_taken;
                if (ack) begin
                    pc_load      = 1'b1;
                    pc_from_pend = !i_br_taken;
                end
            end
            default: ;
        endcase
    end

    // PC, pending redirect target and stalled-fetch buffer.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            pc_q   <= RESET_PC;
            pend_q <= '0;
            buf_q  <= '0;
        end else begin
            if (pc_load) begin
                pc_q <= pc_src & ALIGN_MASK;
            end
            if (pend_load) begin
                pend_q <= i_pc_next & ALIGN_MASK;
            end
            if (buf_load) begin
                buf_q <= i_imem_rdata;
            end
        end
    end

    if_id_reg #(
        .NOP(NOP_INSTR)
    ) u_if_id (
        .clk      (i_clk),
        .rst      (i_reset),
        .flush    (id_flush),
        .hold     (id_hold),
        .load     (id_load),
        .pc       (pc_q),
        .instr    (id_instr),
        .pc_id    (o_pc_id),
        .instr_id (o_instr_id),
        .valid_id (o_valid_id)
    );

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: per-scenario tasks plus an ID-stage scoreboard.
module tb_fetch_unit;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam logic [31:0] NOP      = 32'h0000_0013;
    localparam logic [31:0] KEY      = 32'hA5A5_0000;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } exp_t;

    logic        clk;
    logic        rst;
    logic        br;
    logic        stall;
    logic        ack_zw;
    logic        ack_man;
    logic [31:0] tgt;
    logic [31:0] pc_next;
    logic        req;
    logic [31:0] addr;
    logic        ack;
    logic [31:0] rdata;
    logic [31:0] plus4;
    logic [31:0] pc_id;
    logic [31:0] instr_id;
    logic        valid_id;

    int   checks   = 0;
    int   failures = 0;
    exp_t exp_q[$];
    logic        prev_valid = 1'b0;
    logic [31:0] prev_pc    = '0;

    // Memory model: data = addr ^ KEY; ack either tied to req or driven by the test.
    assign rdata   = addr ^ KEY;
    assign ack     = ack_zw ? req : ack_man;
    assign pc_next = br ? tgt : plus4;

    fetch_unit #(
        .RESET_PC  (RESET_PC),
        .NOP_INSTR (NOP)
    ) dut (
        .i_clk         (clk),
        .i_reset       (rst),
        .i_pc_next     (pc_next),
        .i_br_taken    (br),
        .i_stall_id    (stall),
        .o_imem_req    (req),
        .o_imem_addr   (addr),
        .i_imem_ack    (ack),
        .i_imem_rdata  (rdata),
        .o_pc_plus4_if (plus4),
        .o_pc_id       (pc_id),
        .o_instr_id    (instr_id),
        .o_valid_id    (valid_id)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Scoreboard: every new valid instruction in ID must match the next expected entry.
    always @(negedge clk) begin
        if (rst === 1'b0 && valid_id === 1'b1 && (!prev_valid || pc_id !== prev_pc)) begin
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL sb_unexpected: got pc=%h instr=%h, required none", pc_id, instr_id);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                if (pc_id !== e.pc || instr_id !== e.instr) begin
                    failures++;
                    $display("FAIL sb_order: got pc=%h instr=%h, required pc=%h instr=%h",
                             pc_id, instr_id, e.pc, e.instr);
                end
            end
        end
        prev_valid = (valid_id === 1'b1);
        prev_pc    = pc_id;
    end

    task automatic test_reset;
        rst = 1'b1; br = 1'b0; stall = 1'b0; ack_zw = 1'b0; ack_man = 1'b0; tgt = '0;
        repeat (3) @(negedge clk);
        checks++; if (req !== 1'b0) begin failures++; $display("FAIL rst_req: got %b, required 0", req); end
        checks++; if (addr !== RESET_PC) begin failures++; $display("FAIL rst_addr: got %h, required %h", addr, RESET_PC); end
        checks++; if (pc_id !== 32'h0) begin failures++; $display("FAIL rst_pc_id: got %h, required 0", pc_id); end
        checks++; if (instr_id !== NOP) begin failures++; $display("FAIL rst_instr: got %h, required %h", instr_id, NOP); end
        checks++; if (valid_id !== 1'b0) begin failures++; $display("FAIL rst_valid: got %b, required 0", valid_id); end
        checks++; if (plus4 !== 32'h4) begin failures++; $display("FAIL rst_plus4: got %h, required 4", plus4); end
    endtask

    task automatic test_stream;
        ack_zw = 1'b1;
        for (int i = 0; i < 4; i++) exp_q.push_back('{pc: 32'(4 * i), instr: 32'(4 * i) ^ KEY});
        rst = 1'b0;
        #1;
        checks++; if (req !== 1'b1) begin failures++; $display("FAIL stream_req_rise: got %b, required 1", req); end
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checks++;
            if (pc_id !== 32'(4 * i) || valid_id !== 1'b1 || instr_id !== (32'(4 * i) ^ KEY)) begin
                failures++;
                $display("FAIL stream_step%0d: got pc=%h v=%b instr=%h, required pc=%h v=1 instr=%h",
                         i, pc_id, valid_id, instr_id, 32'(4 * i), 32'(4 * i) ^ KEY);
            end
        end
        ack_zw = 1'b0; ack_man = 1'b0;
    endtask

    task automatic test_wait_states;
        for (int k = 0; k < 2; k++) begin
            logic [31:0] a;
            a = 32'h10 + 32'(4 * k);
            exp_q.push_back('{pc: a, instr: a ^ KEY});
            ack_man = 1'b0;
            @(negedge clk);
            checks++; if (addr !== a || req !== 1'b1) begin failures++; $display("FAIL wait_addr1: got %h req=%b, required %h req=1", addr, req, a); end
            @(negedge clk);
            checks++; if (addr !== a) begin failures++; $display("FAIL wait_addr2: got %h, required %h", addr, a); end
            checks++; if (valid_id !== 1'b0 || instr_id !== NOP) begin failures++; $display("FAIL wait_bubble: got v=%b instr=%h, required v=0 instr=%h", valid_id, instr_id, NOP); end
            ack_man = 1'b1;
            @(negedge clk);
            ack_man = 1'b0;
            checks++; if (pc_id !== a || valid_id !== 1'b1) begin failures++; $display("FAIL wait_arrive: got pc=%h v=%b, required pc=%h v=1", pc_id, valid_id, a); end
        end
    endtask

    task automatic test_stall_on_ack;
        logic [31:0] a;
        a = 32'h18;
        exp_q.push_back('{pc: a, instr: a ^ KEY});
        ack_man = 1'b1; stall = 1'b1;
        for (int h = 0; h < 3; h++) begin
            @(negedge clk);
            checks++;
            if (req !== 1'b0 || addr !== a || pc_id !== 32'h14 || valid_id !== 1'b1) begin
                failures++;
                $display("FAIL stall_hold%0d: got req=%b addr=%h pc_id=%h v=%b, required req=0 addr=%h pc_id=14 v=1",
                         h, req, addr, pc_id, valid_id, a);
            end
        end
        stall = 1'b0; ack_man = 1'b0;
        @(negedge clk);
        checks++; if (pc_id !== a || instr_id !== (a ^ KEY) || valid_id !== 1'b1) begin failures++; $display("FAIL stall_release: got pc=%h instr=%h v=%b, required pc=%h instr=%h v=1", pc_id, instr_id, valid_id, a, a ^ KEY); end
        checks++; if (req !== 1'b1 || addr !== a + 32'h4) begin failures++; $display("FAIL stall_next_fetch: got req=%b addr=%h, required req=1 addr=%h", req, addr, a + 32'h4); end
    endtask

    task automatic test_redirect_drain;
        logic [31:0] b;
        b = 32'h1C;
        br = 1'b1; tgt = 32'h30; ack_man = 1'b0;
        @(negedge clk);
        br = 1'b0;
        checks++; if (req !== 1'b1 || addr !== b || valid_id !== 1'b0) begin failures++; $display("FAIL drain_enter: got req=%b addr=%h v=%b, required req=1 addr=%h v=0", req, addr, valid_id, b); end
        br = 1'b1; tgt = 32'h40;
        @(negedge clk);
        br = 1'b0;
        checks++; if (addr !== b || req !== 1'b1) begin failures++; $display("FAIL drain_stable: got addr=%h req=%b, required addr=%h req=1", addr, req, b); end
        ack_man = 1'b1;
        @(negedge clk);
        ack_man = 1'b0;
        checks++; if (addr !== 32'h40 || req !== 1'b1 || valid_id !== 1'b0) begin failures++; $display("FAIL drain_target: got addr=%h req=%b v=%b, required addr=40 req=1 v=0", addr, req, valid_id); end
    endtask

    task automatic test_flush_beats_stall;
        exp_q.push_back('{pc: 32'h40, instr: 32'h40 ^ KEY});
        ack_man = 1'b1;
        @(negedge clk);
        checks++; if (pc_id !== 32'h40 || valid_id !== 1'b1) begin failures++; $display("FAIL flush_pre: got pc=%h v=%b, required pc=40 v=1", pc_id, valid_id); end
        br = 1'b1; stall = 1'b1; tgt = 32'h80;
        @(negedge clk);
        br = 1'b0; stall = 1'b0; ack_man = 1'b0;
        checks++; if (valid_id !== 1'b0 || instr_id !== NOP) begin failures++; $display("FAIL flush_bubble: got v=%b instr=%h, required v=0 instr=%h", valid_id, instr_id, NOP); end
        checks++; if (addr !== 32'h80 || req !== 1'b1) begin failures++; $display("FAIL flush_target: got addr=%h req=%b, required addr=80 req=1", addr, req); end
    endtask

    task automatic test_reset_mid_drain;
        br = 1'b1; tgt = 32'hC0; ack_man = 1'b0;
        @(negedge clk);
        br = 1'b0;
        checks++; if (req !== 1'b1 || addr !== 32'h80) begin failures++; $display("FAIL mid_drain: got req=%b addr=%h, required req=1 addr=80", req, addr); end
        #2 rst = 1'b1;
        #1;
        checks++; if (req !== 1'b0 || addr !== RESET_PC) begin failures++; $display("FAIL async_rst_if: got req=%b addr=%h, required req=0 addr=%h", req, addr, RESET_PC); end
        checks++; if (pc_id !== 32'h0 || instr_id !== NOP || valid_id !== 1'b0) begin failures++; $display("FAIL async_rst_id: got pc=%h instr=%h v=%b, required pc=0 instr=%h v=0", pc_id, instr_id, valid_id, NOP); end
        @(negedge clk);
        rst = 1'b0;
        #1;
        checks++; if (req !== 1'b1 || addr !== RESET_PC) begin failures++; $display("FAIL rst_first_req: got req=%b addr=%h, required req=1 addr=%h", req, addr, RESET_PC); end
        exp_q.push_back('{pc: RESET_PC, instr: RESET_PC ^ KEY});
        ack_man = 1'b1;
        @(negedge clk);
        ack_man = 1'b0;
        checks++; if (pc_id !== RESET_PC || valid_id !== 1'b1) begin failures++; $display("FAIL rst_first_instr: got pc=%h v=%b, required pc=%h v=1", pc_id, valid_id, RESET_PC); end
    endtask

    task automatic test_wrap;
        br = 1'b1; tgt = 32'hFFFF_FFFF; ack_man = 1'b1;
        @(negedge clk);
        br = 1'b0;
        checks++; if (addr !== 32'hFFFF_FFFC || plus4 !== 32'h0) begin failures++; $display("FAIL wrap_align: got addr=%h plus4=%h, required addr=fffffffc plus4=0", addr, plus4); end
        exp_q.push_back('{pc: 32'hFFFF_FFFC, instr: 32'hFFFF_FFFC ^ KEY});
        @(negedge clk);
        ack_man = 1'b0;
        checks++; if (pc_id !== 32'hFFFF_FFFC || valid_id !== 1'b1) begin failures++; $display("FAIL wrap_id: got pc=%h v=%b, required pc=fffffffc v=1", pc_id, valid_id); end
        checks++; if (addr !== 32'h0 || plus4 !== 32'h4) begin failures++; $display("FAIL wrap_pc: got addr=%h plus4=%h, required addr=0 plus4=4", addr, plus4); end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_wait_states();
        test_stall_on_ack();
        test_redirect_drain();
        test_flush_beats_stall();
        test_reset_mid_drain();
        test_wrap();
        @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL sb_drain: got %0d pending, required 0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
